acc_core: RTL and testbench
===========================

Name: acc_core

Overview:
- Three-input carry (majority) block for the ADDAC adder datapath.
- Output saida is the purely combinational carry of a, b, c, i.e. the full-adder carry-out.
- The block also contains a clocked bit-serial adder that reuses the same carry function.
- The serial adder accumulates WIDTH-bit sums LSB-first for the surrounding control logic.

Parameters:
- WIDTH, 8, operand/sum width in bits of the serial adder (legal range 2..32).

Ports:
- clk  input  1  single clock; all registers update on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- a  input  1  operand bit A (combinational and serial paths).
- b  input  1  operand bit B (combinational and serial paths).
- c  input  1  carry-in: combinational path input; also the initial serial carry, loaded on start.
- saida  output  1  combinational carry = (a&b)|(a&c)|(b&c).
- soma  output  1  combinational sum = a^b^c.
- start  input  1  begin a new serial addition.
- bit_valid  input  1  a/b hold a valid serial operand bit this cycle.
- busy  output  1  serial addition in progress.
- done  output  1  one-cycle pulse: WIDTH bits have been consumed.
- carry_q  output  1  registered running carry.
- sum_q  output  WIDTH  serial sum shift register.
- bit_cnt  output  $clog2(WIDTH+1)  bits consumed so far.

Behaviour:
- saida and soma:
  - Pure combinational functions of a, b, c.
  - Independent of clk, reset_n, busy and start.
  - Must settle within one clock period.
- Required truth table for saida (abc->saida): 000->0, 001->0, 010->0, 011->1, 100->0, 101->1, 110->1, 111->1.
- Reset (reset_n=0, asynchronous): busy=0, done=0, carry_q=0, sum_q=0, bit_cnt=0. Registers hold these values until reset_n rises.
- States are IDLE (busy=0) and RUN (busy=1).
- start=1, any state:
  - carry_q<=c, sum_q<=0, bit_cnt<=0, busy<=1, done<=0.
  - A start during RUN aborts the current addition and restarts.
- RUN with bit_valid=1 and start=0:
  - carry_q <= maj(a,b,carry_q).
  - sum_q <= {a^b^carry_q, sum_q[WIDTH-1:1]} (shift right, new bit into MSB).
  - bit_cnt <= bit_cnt+1.
- RUN, bit_valid=0: all registers hold.
- On the bit_valid edge that makes bit_cnt==WIDTH:
  - busy<=0 and done<=1 for exactly one cycle.
  - sum_q then holds the full WIDTH-bit sum, LSB at bit 0.
  - carry_q holds the final carry-out.
- IDLE:
  - bit_valid is ignored.
  - sum_q, carry_q and bit_cnt hold their last values until the next start or reset.
- start and bit_valid in the same cycle: start wins and the bit is discarded.
- Width rule: result = A + B + c_init modulo 2^WIDTH; the overflow appears on carry_q.
- Latency:
  - saida/soma: 0 cycles.
  - Serial result: valid in the cycle done=1, i.e. WIDTH valid-bit cycles after start.

Decomposition:
- Shared package addac_pkg:
  - function maj3(a,b,c);
  - constant ACC_DEFAULT_WIDTH=8;
  - state enum typedef acc_state_t {IDLE, RUN}.
- One natural sub-module: acc_fa_cell, a combinational full-adder cell (sum, carry).
  - Instantiated once for the a/b/c combinational outputs.
  - Instantiated once for the serial datapath (a, b, carry_q).

Test Plan:
- Combinational sweep: apply all 8 abc codes with reset_n both 0 and 1 -> saida per the truth table (e.g. 011->1, 100->0, 111->1); soma = odd parity (e.g. 111->1, 110->0).
- Serial add, WIDTH=8: start with c=0, feed A=0x5A, B=0x3C LSB-first over 8 bit_valid cycles -> done pulse once, sum_q=0x96, carry_q=0, busy=0.
- Overflow: start with c=0, A=0xFF, B=0x01 -> sum_q=0x00, carry_q=1. Repeat with c=1, A=0x00, B=0x00 -> sum_q=0x01, carry_q=0.
- Gaps and collision:
  - Insert bit_valid=0 gaps mid-operation -> same result as the gap-free run.
  - Assert start together with bit_valid at bit 3 -> bit_cnt=0, sum_q=0, carry_q=c.
- Asynchronous reset mid-operation: drop reset_n between clock edges after 4 bits -> outputs immediately busy=0, done=0, carry_q=0, sum_q=0, bit_cnt=0. A fresh start afterwards computes correctly.
- Idle robustness: bit_valid pulses while busy=0 -> sum_q, carry_q and bit_cnt unchanged, no done pulse.

Source files
------------

// File: rtl/addac_pkg.sv
// Shared definitions for the ADDAC adder datapath: majority carry, default width, serial FSM states.
package addac_pkg;

  localparam int ACC_DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } acc_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/acc_fa_cell.sv
// Full-adder cell: sum and majority carry of three bits.
// Latency: 0 cycles (pure combinational). Backpressure: none.
module acc_fa_cell
  import addac_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic z,
  output logic sum,
  output logic carry
);

  assign sum   = x ^ y ^ z;
  assign carry = maj3(x, y, z);

endmodule

// File: rtl/acc_core.sv
// Combinational full-adder carry/sum on a,b,c plus an LSB-first bit-serial WIDTH-bit adder.
// Latency: saida/soma 0 cycles; serial result in the done cycle. Backpressure: bit_valid gaps stall.
module acc_core
  import addac_pkg::*;
#(
  parameter int WIDTH = ACC_DEFAULT_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       a,
  input  logic                       b,
  input  logic                       c,
  output logic                       saida,
  output logic                       soma,
  input  logic                       start,
  input  logic                       bit_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       carry_q,
  output logic [WIDTH-1:0]           sum_q,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH+1);

  acc_state_t state, state_nxt;
  logic       ser_sum;
  logic       ser_carry;
  logic       take_bit;
  logic       last_bit;

  acc_fa_cell u_fa_comb (
    .x     (a),
    .y     (b),
    .z     (c),
    .sum   (soma),
    .carry (saida)
  );

  acc_fa_cell u_fa_serial (
    .x     (a),
    .y     (b),
    .z     (carry_q),
    .sum   (ser_sum),
    .carry (ser_carry)
  );

  // start has priority over an incoming bit in the same cycle
  assign take_bit = (state == RUN) && bit_valid && !start;
  assign last_bit = take_bit && (bit_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = RUN;
    end else if (last_bit) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done    <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        carry_q <= c;
        sum_q   <= '0;
        bit_cnt <= '0;
      end else if (take_bit) begin
        carry_q <= ser_carry;
        sum_q   <= {ser_sum, sum_q[WIDTH-1:1]};
        bit_cnt <= bit_cnt + CW'(1);
        done    <= last_bit;
      end
    end
  end

endmodule

// File: tb/tb_acc_core.sv
// Self-checking bench for acc_core: combinational carry/sum sweep and serial adder scenarios.
module tb_acc_core;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          a, b, c;
  logic          saida, soma;
  logic          start, bit_valid;
  logic          busy, done, carry_q;
  logic [W-1:0]  sum_q;
  logic [CW-1:0] bit_cnt;

  int tests = 0;
  int fails = 0;

  // expected {carry, sum} for each started addition that is expected to complete
  logic [W:0] sb[$];

  acc_core #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .saida     (saida),
    .soma      (soma),
    .start     (start),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done),
    .carry_q   (carry_q),
    .sum_q     (sum_q),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  // Drives one complete serial addition; gap_mask[i] inserts an idle cycle before bit i.
  task automatic serial_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cin,
                           input logic [W-1:0] gap_mask, output logic [W-1:0] s,
                           output logic cq, output int dones, output logic last_done);
    sb.push_back({1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cin});
    dones = 0;
    last_done = 1'b0;
    @(negedge clk);
    start = 1'b1; c = cin; bit_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; c = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (gap_mask[i]) begin
        bit_valid = 1'b0;
        @(negedge clk);
        dones += int'(done);
      end
      a = av[i]; b = bv[i]; bit_valid = 1'b1;
      @(negedge clk);
      dones += int'(done);
      if (i == W - 1) last_done = done;
    end
    bit_valid = 1'b0; a = 1'b0; b = 1'b0;
    s = sum_q; cq = carry_q;
    @(negedge clk);
    dones += int'(done);
  endtask

  task automatic check_op(input string name, input logic [W-1:0] s, input logic cq,
                          input int dones, input logic last_done);
    logic [W:0] exp;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    exp = sb.pop_front();
    if (s !== exp[W-1:0] || cq !== exp[W]) begin
      fails++;
      $display("FAIL %s result: got sum=%h carry=%b, want sum=%h carry=%b",
               name, s, cq, exp[W-1:0], exp[W]);
    end
    tests++;
    if (dones !== 1 || last_done !== 1'b1) begin
      fails++;
      $display("FAIL %s done: got %0d pulses (at last bit=%b), want 1 at last bit",
               name, dones, last_done);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; bit_valid = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
    #12;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || carry_q !== 1'b0 || sum_q !== '0 || bit_cnt !== '0) begin
      fails++;
      $display("FAIL reset_state: got busy=%b done=%b carry=%b sum=%h cnt=%0d, want all 0",
               busy, done, carry_q, sum_q, bit_cnt);
    end
  endtask

  task automatic test_comb();
    logic [7:0] tt;
    logic [2:0] code;
    tt = 8'b1110_1000;
    for (int r = 0; r < 2; r++) begin
      reset_n = r[0];
      for (int k = 0; k < 8; k++) begin
        code = k[2:0];
        {a, b, c} = code;
        #1;
        tests++;
        if (saida !== tt[k] || soma !== ^code) begin
          fails++;
          $display("FAIL comb abc=%b rst_n=%0d: got saida=%b soma=%b, want saida=%b soma=%b",
                   code, r, saida, soma, tt[k], ^code);
        end
      end
    end
    a = 1'b0; b = 1'b0; c = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_serial();
    logic [W-1:0] s; logic cq, ld; int d;
    serial_op(8'h5A, 8'h3C, 1'b0, '0, s, cq, d, ld);
    check_op("serial_5a_3c", s, cq, d, ld);
    tests++;
    if (s !== 8'h96 || busy !== 1'b0 || bit_cnt !== CW'(W)) begin
      fails++;
      $display("FAIL serial_final: got sum=%h busy=%b cnt=%0d, want 96 0 %0d", s, busy, bit_cnt, W);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] s; logic cq, ld; int d;
    serial_op(8'hFF, 8'h01, 1'b0, '0, s, cq, d, ld);
    check_op("ovf_ff_01", s, cq, d, ld);
    serial_op(8'h00, 8'h00, 1'b1, '0, s, cq, d, ld);
    check_op("cin_only", s, cq, d, ld);
    serial_op(8'hA7, 8'hC3, 1'b1, '0, s, cq, d, ld);
    check_op("mixed_cin1", s, cq, d, ld);
  endtask

  task automatic test_gaps();
    logic [W-1:0] s; logic cq, ld; int d;
    serial_op(8'h5A, 8'h3C, 1'b0, 8'b0101_0110, s, cq, d, ld);
    check_op("gaps_5a_3c", s, cq, d, ld);
    serial_op(8'hFF, 8'h01, 1'b0, 8'b1000_0001, s, cq, d, ld);
    check_op("gaps_ovf", s, cq, d, ld);
  endtask

  task automatic test_collision();
    logic [W-1:0] s; logic cq, ld; int d;
    @(negedge clk);
    start = 1'b1; c = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 1'b1; b = 1'b1; bit_valid = 1'b1;
      @(negedge clk);
    end
    start = 1'b1; c = 1'b1; a = 1'b1; b = 1'b0; bit_valid = 1'b1;
    @(negedge clk);
    start = 1'b0; bit_valid = 1'b0; c = 1'b0;
    tests++;
    if (bit_cnt !== '0 || sum_q !== '0 || carry_q !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL collision: got cnt=%0d sum=%h carry=%b busy=%b done=%b, want 0 00 1 1 0",
               bit_cnt, sum_q, carry_q, busy, done);
    end
    serial_op(8'h12, 8'h34, 1'b0, '0, s, cq, d, ld);
    check_op("after_collision", s, cq, d, ld);
  endtask

  task automatic test_async_reset();
    logic [W-1:0] s; logic cq, ld; int d;
    @(negedge clk);
    start = 1'b1; c = 1'b1;
    @(negedge clk);
    start = 1'b0; c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 1'b1; b = 1'b0; bit_valid = 1'b1;
      @(negedge clk);
    end
    bit_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || carry_q !== 1'b0 || sum_q !== '0 || bit_cnt !== '0) begin
      fails++;
      $display("FAIL async_reset: got busy=%b done=%b carry=%b sum=%h cnt=%0d, want all 0",
               busy, done, carry_q, sum_q, bit_cnt);
    end
    @(negedge clk);
    reset_n = 1'b1;
    serial_op(8'h7F, 8'h81, 1'b1, '0, s, cq, d, ld);
    check_op("after_reset", s, cq, d, ld);
  endtask

  task automatic test_idle();
    logic [W-1:0] s; logic cq, ld; int d, extra;
    serial_op(8'h0F, 8'h0E, 1'b0, '0, s, cq, d, ld);
    check_op("pre_idle", s, cq, d, ld);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      a = 1'b1; b = 1'b1; bit_valid = 1'b1;
      @(negedge clk);
      extra += int'(done);
    end
    bit_valid = 1'b0;
    tests++;
    if (sum_q !== 8'h1D || carry_q !== 1'b0 || bit_cnt !== CW'(W) || extra !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_hold: got sum=%h carry=%b cnt=%0d dones=%0d busy=%b, want 1d 0 %0d 0 0",
               sum_q, carry_q, bit_cnt, extra, busy, W);
    end
  endtask

  initial begin
    test_reset();
    test_comb();
    test_serial();
    test_overflow();
    test_gaps();
    test_collision();
    test_async_reset();
    test_idle();
    tests++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
